// File: rtl/sr_ctrl_pkg.sv
// Shared types, default sizes and the counting helper for the SR counter sequencer.
package sr_ctrl_pkg;

  localparam int unsigned DefWidth    = 2;
  localparam int unsigned DefPulseCyc = 1;
  localparam int unsigned DefMaxRetry = 2;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StDrive,
    StRelease,
    StVerify,
    StError
  } state_e;

  // Step cnt up or down by one, wrapping modulo 2^width.
  function automatic logic [31:0] next_count(logic [31:0] cnt, logic dir, int unsigned width);
    logic [31:0] mask;
    logic [31:0] nxt;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    nxt  = dir ? (cnt + 32'd1) : (cnt - 32'd1);
    return nxt & mask;
  endfunction

endpackage

// File: rtl/sr_counter_sequencer_if.sv
// Request, SR-bank and status signals of the SR counter sequencer.
interface sr_counter_sequencer_if #(
  parameter int unsigned WIDTH = 2
);
  logic             en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_err;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] s_out;
  logic [WIDTH-1:0] r_out;
  logic             sr_reset;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             err;

  modport master (
    output en, dir, load, load_val, clr_err, q_fb,
    input  s_out, r_out, sr_reset, count, tc, busy, err
  );

  modport slave (
    input  en, dir, load, load_val, clr_err, q_fb,
    output s_out, r_out, sr_reset, count, tc, busy, err
  );
endinterface

// File: rtl/sr_cmd_encoder.sv
// Turns a target value into per-bit S/R commands; both vectors are zero unless driving,
// so S and R can never be high together on any bit.
module sr_cmd_encoder #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] target,
  input  logic             drive_en,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);

  // Gate the complementary command pair with drive_en.
  always_comb begin
    s = '0;
    r = '0;
    if (drive_en) begin
      s = target;
      r = ~target;
    end
  end

endmodule

// File: rtl/sr_counter_sequencer.sv
// Sequenced up/down counter built on an external SR flip-flop bank: drive, release,
// read back, and commit the count only when the bank holds the target.
module sr_counter_sequencer
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned PULSE_CYC = DefPulseCyc,
  parameter int unsigned MAX_RETRY = DefMaxRetry
) (
  input logic                     clk,
  input logic                     reset,
  sr_counter_sequencer_if.slave   bus
);

  localparam int unsigned PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [PW-1:0]    pulse_q, pulse_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             sr_reset_q, sr_reset_d;

  // S/R outputs are registered from the next state so they line up with DRIVE cycles.
  sr_cmd_encoder #(
    .WIDTH (WIDTH)
  ) u_enc (
    .target   (target_d),
    .drive_en (state_d == StDrive),
    .s        (s_d),
    .r        (r_d)
  );

  // Next-state, target, pulse/retry counters and committed count.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    pulse_d  = pulse_q;
    retry_d  = retry_q;
    count_d  = count_q;
    err_d    = err_q;
    unique case (state_q)
      StClear: begin
        target_d = '0;
        retry_d  = '0;
        state_d  = StVerify;
      end
      StIdle: begin
        retry_d = '0;
        if (bus.load) begin
          target_d = bus.load_val;
          pulse_d  = '0;
          state_d  = StDrive;
        end else if (bus.en) begin
          target_d = WIDTH'(next_count(32'(count_q), bus.dir, WIDTH));
          pulse_d  = '0;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        if (pulse_q == PW'(PULSE_CYC - 1)) begin
          state_d = StRelease;
        end else begin
          pulse_d = pulse_q + PW'(1);
        end
      end
      StRelease: state_d = StVerify;
      StVerify: begin
        if (bus.q_fb == target_q) begin
          count_d = target_q;
          retry_d = '0;
          state_d = StIdle;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          pulse_d = '0;
          state_d = StDrive;
        end else begin
          err_d   = 1'b1;
          state_d = StError;
        end
      end
      StError: begin
        if (bus.clr_err) begin
          err_d   = 1'b0;
          state_d = StClear;
        end
      end
      default: state_d = StClear;
    endcase
    sr_reset_d = (state_d == StClear);
  end

  // State and registered outputs; reset forces S/R low immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StClear;
      target_q   <= '0;
      pulse_q    <= '0;
      retry_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      s_q        <= '0;
      r_q        <= '0;
      sr_reset_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      pulse_q    <= pulse_d;
      retry_q    <= retry_d;
      count_q    <= count_d;
      err_q      <= err_d;
      s_q        <= s_d;
      r_q        <= r_d;
      sr_reset_q <= sr_reset_d;
    end
  end

  assign bus.s_out    = s_q;
  assign bus.r_out    = r_q;
  assign bus.sr_reset = sr_reset_q;
  assign bus.count    = count_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.tc       = bus.dir ? (count_q == '1) : (count_q == '0);

endmodule

// File: tb/tb_sr_counter_sequencer.sv
// Self-checking bench: ideal SR bank on q_fb, table vectors, corner sequences, random ops.
module tb_sr_counter_sequencer;

  localparam int unsigned W = 2;
  localparam int unsigned P = 1;
  localparam int unsigned M = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sr_counter_sequencer_if #(.WIDTH(W)) bus ();

  sr_counter_sequencer #(
    .WIDTH     (W),
    .PULSE_CYC (P),
    .MAX_RETRY (M)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Ideal SR bank with an optional stuck-at-zero mask on the readback.
  logic [W-1:0] bank_q = '0;
  logic [W-1:0] stuck_zero = '0;
  always @(posedge clk) begin
    if (bus.sr_reset === 1'b1) bank_q <= '0;
    else                       bank_q <= (bank_q | bus.s_out) & ~bus.r_out;
  end
  assign bus.q_fb = bank_q & ~stuck_zero;

  int tests = 0;
  int fails = 0;
  bit mon_on = 1'b0;
  int model_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // S and R never both high; all quiet while idle or in error.
  always @(negedge clk) begin
    if (mon_on && !reset) begin
      check("sr_overlap", 32'(bus.s_out & bus.r_out), 32'd0);
      if (bus.busy === 1'b0 || bus.err === 1'b1)
        check("sr_quiet", 32'(bus.s_out | bus.r_out), 32'd0);
    end
  end

  function automatic logic [W-1:0] ref_next(int cur, bit ld, bit e, bit d, logic [W-1:0] v);
    int m;
    m = 1 << W;
    if (ld) return v;
    if (e) return W'(d ? (cur + 1) % m : (cur + m - 1) % m);
    return W'(cur);
  endfunction

  // Wait (bounded) for busy to drop; returns edges taken.
  task automatic wait_idle(output int lat);
    lat = 0;
    while (bus.busy !== 1'b0 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One request in IDLE, checked against expected new count.
  task automatic do_op(input bit ld, input bit e, input bit d, input logic [W-1:0] v,
                       input logic [W-1:0] exp, input string tag);
    int lat;
    @(negedge clk);
    bus.load = ld; bus.en = e; bus.dir = d; bus.load_val = v;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.en = 1'b0;
    if (ld || e) begin
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_s"}, 32'(bus.s_out), 32'(exp));
      check({tag, "_r"}, 32'(bus.r_out), 32'(W'(~exp)));
      wait_idle(lat);
      check({tag, "_lat"}, 32'(lat), 32'(P + 2));
    end else begin
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    end
    check({tag, "_count"}, 32'(bus.count), 32'(exp));
    check({tag, "_tc"}, 32'(bus.tc), 32'(d ? (exp == W'((1 << W) - 1)) : (exp == '0)));
    model_count = int'(exp);
  endtask

  typedef struct {
    bit           ld;
    bit           en;
    bit           dir;
    logic [W-1:0] val;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int lat;
    int drives;
    bit ld, e, d;
    logic [W-1:0] v;

    tbl[0]  = '{0, 1, 1, 2'd0, 2'd1};
    tbl[1]  = '{0, 1, 1, 2'd0, 2'd2};
    tbl[2]  = '{0, 1, 1, 2'd0, 2'd3};
    tbl[3]  = '{0, 1, 1, 2'd0, 2'd0};  // up wrap
    tbl[4]  = '{0, 1, 0, 2'd0, 2'd3};  // down wrap, S=11 R=00
    tbl[5]  = '{0, 1, 0, 2'd0, 2'd2};
    tbl[6]  = '{1, 1, 1, 2'd2, 2'd2};  // load beats en
    tbl[7]  = '{1, 0, 0, 2'd1, 2'd1};
    tbl[8]  = '{0, 0, 1, 2'd3, 2'd1};  // no request
    tbl[9]  = '{0, 1, 0, 2'd0, 2'd0};
    tbl[10] = '{0, 1, 0, 2'd0, 2'd3};

    reset = 1'b1;
    bus.en = 1'b0; bus.dir = 1'b1; bus.load = 1'b0; bus.load_val = '0; bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sr_reset", 32'(bus.sr_reset), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_s", 32'(bus.s_out), 32'd0);
    check("rst_r", 32'(bus.r_out), 32'd0);
    mon_on = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    wait_idle(lat);
    check("rst_clear_lat", 32'(lat + 1), 32'd2);
    check("rst_idle_count", 32'(bus.count), 32'd0);
    check("rst_idle_sr_reset", 32'(bus.sr_reset), 32'd0);

    for (int i = 0; i < 11; i++)
      do_op(tbl[i].ld, tbl[i].en, tbl[i].dir, tbl[i].val, tbl[i].exp, $sformatf("tbl%0d", i));

    // Reset while driving.
    do_op(1'b1, 1'b0, 1'b1, 2'd1, 2'd1, "pre_rst");
    @(negedge clk);
    bus.en = 1'b1; bus.dir = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    check("mid_drive_s", 32'(bus.s_out), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_s", 32'(bus.s_out), 32'd0);
    check("mid_rst_r", 32'(bus.r_out), 32'd0);
    check("mid_rst_sr_reset", 32'(bus.sr_reset), 32'd1);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    wait_idle(lat);
    check("mid_rst_lat", 32'(lat + 1), 32'd2);
    check("mid_rst_final", 32'(bus.count), 32'd0);
    model_count = 0;

    // Stuck bit 1 at zero while loading 2.
    do_op(1'b1, 1'b0, 1'b1, 2'd1, 2'd1, "pre_stuck");
    stuck_zero = 2'b10;
    @(negedge clk);
    bus.load = 1'b1; bus.load_val = 2'd2;
    @(posedge clk); #1;
    bus.load = 1'b0;
    drives = (bus.s_out != '0) ? 1 : 0;
    lat = 0;
    while (bus.err !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (bus.s_out != '0) drives++;
    end
    check("stuck_drives", 32'(drives), 32'(M + 1));
    check("stuck_err", 32'(bus.err), 32'd1);
    check("stuck_busy", 32'(bus.busy), 32'd1);
    check("stuck_sr", 32'(bus.s_out | bus.r_out), 32'd0);
    check("stuck_count", 32'(bus.count), 32'(model_count));
    repeat (3) @(posedge clk);
    #1;
    check("stuck_sticky", 32'(bus.err), 32'd1);
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(posedge clk); #1;
    bus.clr_err = 1'b0;
    check("clr_sr_reset", 32'(bus.sr_reset), 32'd1);
    check("clr_err", 32'(bus.err), 32'd0);
    @(posedge clk); #1;
    check("clr_pulse_end", 32'(bus.sr_reset), 32'd0);
    wait_idle(lat);
    check("clr_count", 32'(bus.count), 32'd0);
    check("clr_idle_err", 32'(bus.err), 32'd0);
    stuck_zero = '0;
    model_count = 0;

    // Random requests against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ld = ($urandom_range(0, 3) == 0);
      e  = $urandom_range(0, 1) == 1;
      d  = $urandom_range(0, 1) == 1;
      v  = W'($urandom_range(0, (1 << W) - 1));
      do_op(ld, e, d, v, ref_next(model_count, ld, e, d, v), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
